// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: default payload and
// counter widths, plus the packed layout of the decoded control word.
package pipe_pkg;

  localparam int CTRL_W_DEF = 16;
  localparam int DATA_W_DEF = 160;
  localparam int CNT_W_DEF  = 16;

  // Decoded control bundle carried alongside each instruction. Occupies the
  // low bits of the control payload; the remaining upper bits are spare.
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       invert_zero;
    logic       jump;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  localparam int CTRL_T_W = $bits(ctrl_t);

  // Zero-extend a decoded control bundle to the default payload width.
  function automatic logic [CTRL_W_DEF-1:0] ctrl_pack(input ctrl_t c);
    return {{(CTRL_W_DEF - CTRL_T_W){1'b0}}, c};
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: a head register that drives the stage outputs and
// one overflow register that absorbs the entry accepted during the cycle the
// downstream first stalls. in_ready depends only on stored state (and reset),
// never on out_ready.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              head_free;

  // Only a full overflow slot (which implies a full head) refuses input.
  assign in_ready  = reset && !skid_valid;
  assign accept    = in_valid && in_ready;
  assign head_free = !out_valid || out_ready;

  // Head register and occupancy: reset beats flush, flush beats transfers.
  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // block samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      skid_valid <= 1'b0;
    end else if (head_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_ctrl   <= skid_ctrl;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_ctrl  <= in_ctrl;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
        out_ctrl  <= '0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // Overflow payload capture while the head is stalled.
  // NOTE: the overflow payload is deliberately not reset; skid_valid alone
  // marks it empty and it is only ever copied to the head when skid_valid is set.
  always_ff @(posedge clock) begin
    if (accept && !head_free) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, and a saturating
// back-pressure counter. Define PIPE_STAGE_SKID_EN to build the two-entry skid
// buffer variant (registered in_ready); the default build is a single entry
// whose in_ready follows out_ready combinationally.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

`ifdef PIPE_STAGE_SKID_EN

  pipe_skid_buf #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_skid_buf (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data)
  );

`else

  logic accept;

  // The single slot can take a new entry when empty or draining this cycle.
  assign in_ready = reset && (out_ready || !out_valid);
  assign accept   = in_valid && in_ready;

  // Single-entry register: reset beats flush, flush beats transfers; data is
  // held across bubbles while control is zeroed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_ctrl  <= in_ctrl;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end
  end

`endif

  // Count back-pressured cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. A queue-based model of the stage
// (ordered list of held entries plus the last presented data word) is checked
// against the DUT every cycle; directed scenarios add literal expectations.
module tb_pipe_stage_reg;

  localparam int CTRL_W  = 16;
  localparam int DATA_W  = 160;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .flush    (flush),
    .stall_cnt(stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              q[$];
  logic [DATA_W-1:0] last_data = '0;
  int                m_cnt = 0;

  function automatic bit m_in_ready();
    if (reset !== 1'b1) return 1'b0;
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || (out_ready === 1'b1);
  endfunction

  function automatic logic [CTRL_W-1:0] m_ctrl();
    return (q.size() != 0) ? q[0].c : '0;
  endfunction

  function automatic logic [DATA_W-1:0] m_data();
    return (q.size() != 0) ? q[0].d : last_data;
  endfunction

  always @(posedge clock) begin
    bit   acc;
    bit   drn;
    ent_t e;
    acc = in_valid && m_in_ready();
    drn = (q.size() != 0) && out_ready;
    e.c = in_ctrl;
    e.d = in_data;
    if (!reset) begin
      q.delete();
      last_data = '0;
      m_cnt     = 0;
    end else if (flush) begin
      if (q.size() != 0) last_data = q[0].d;
      q.delete();
    end else begin
      if ((q.size() != 0) && !out_ready && (m_cnt < CNT_MAX)) m_cnt++;
      if (drn) begin
        last_data = q[0].d;
        void'(q.pop_front());
      end
      if (acc) q.push_back(e);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("out_valid", DATA_W'(out_valid), DATA_W'(q.size() != 0));
      check("out_ctrl",  DATA_W'(out_ctrl),  DATA_W'(m_ctrl()));
      check("out_data",  out_data,           m_data());
      check("stall_cnt", DATA_W'(stall_cnt), DATA_W'(m_cnt));
      check("in_ready",  DATA_W'(in_ready),  DATA_W'(m_in_ready()));
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] dlog[$];

  // Apply one cycle of inputs, note any output transfer, then advance.
  task automatic step(input logic v, input logic [CTRL_W-1:0] c,
                      input logic [DATA_W-1:0] d, input logic r,
                      input logic f, input logic rs);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = r;
    flush     = f;
    reset     = rs;
    #1;
    if (out_valid && out_ready && reset && !flush) dlog.push_back(out_data[15:0]);
    @(negedge clock);
    #1;
  endtask

  logic [31:0] vpat;
  logic [31:0] rpat;

  initial begin
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
    @(negedge clock);
    #1;
    cmp_en = 1'b1;

    // Reset state.
    step(1'b1, 16'h00FF, 160'hDEAD, 1'b1, 1'b0, 1'b0);
    check("rst_out_valid", DATA_W'(out_valid), '0);
    check("rst_out_ctrl",  DATA_W'(out_ctrl),  '0);
    check("rst_out_data",  out_data,           '0);
    check("rst_stall_cnt", DATA_W'(stall_cnt), '0);
    check("rst_in_ready",  DATA_W'(in_ready),  '0);

    // Release: ready on the first cycle out of reset.
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    check("rel_in_ready", DATA_W'(in_ready), DATA_W'(1));

    // Single entry, one-cycle latency, then bubble holds data.
    step(1'b1, 16'h00A5, 160'h1234, 1'b1, 1'b0, 1'b1);
    check("one_valid", DATA_W'(out_valid), DATA_W'(1));
    check("one_ctrl",  DATA_W'(out_ctrl),  DATA_W'(16'h00A5));
    check("one_data",  out_data,           160'h1234);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    check("bub_valid", DATA_W'(out_valid), '0);
    check("bub_ctrl",  DATA_W'(out_ctrl),  '0);
    check("bub_data",  out_data,           160'h1234);

    // Stream of 8 at full rate.
    dlog.delete();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, CTRL_W'(16'h0010 + k), DATA_W'(k + 1), 1'b1, 1'b0, 1'b1);
      check("stream_valid", DATA_W'(out_valid), DATA_W'(1));
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    check("stream_count", DATA_W'(dlog.size()), DATA_W'(8));
    for (int k = 0; k < 8; k++) begin
      check("stream_order", DATA_W'(dlog[k]), DATA_W'(k + 1));
    end
    check("stream_stall", DATA_W'(stall_cnt), '0);

    // Held entry under 5 cycles of back-pressure.
    step(1'b1, 16'h0021, 160'hAA, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 16'h0022, 160'hBB, 1'b0, 1'b0, 1'b1);
      check("hold_ctrl", DATA_W'(out_ctrl), DATA_W'(16'h0021));
      check("hold_data", out_data, 160'hAA);
    end
    check("hold_valid", DATA_W'(out_valid), DATA_W'(1));
    check("hold_stall", DATA_W'(stall_cnt), DATA_W'(5));
    check("hold_in_ready", DATA_W'(in_ready), '0);

    // Flush with entries held and a new one offered.
    dlog.delete();
    step(1'b1, 16'h0023, 160'hCC, 1'b0, 1'b1, 1'b1);
    check("flush_valid", DATA_W'(out_valid), '0);
    check("flush_ctrl",  DATA_W'(out_ctrl),  '0);
    check("flush_data",  out_data,           160'hAA);
    check("flush_ready", DATA_W'(in_ready),  DATA_W'(1));
    check("flush_stall", DATA_W'(stall_cnt), DATA_W'(5));
    for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    check("flush_none_out", DATA_W'(dlog.size()), '0);

    // Reset asserted mid-stall together with flush.
    step(1'b1, 16'h0024, 160'h77, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("pre_rst_stall", DATA_W'(stall_cnt), DATA_W'(7));
    step(1'b1, 16'h0025, 160'h88, 1'b0, 1'b1, 1'b0);
    check("mid_rst_valid", DATA_W'(out_valid), '0);
    check("mid_rst_ctrl",  DATA_W'(out_ctrl),  '0);
    check("mid_rst_data",  out_data,           '0);
    check("mid_rst_stall", DATA_W'(stall_cnt), '0);
    check("mid_rst_ready", DATA_W'(in_ready),  '0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("post_rst_ready", DATA_W'(in_ready),  DATA_W'(1));
    check("post_rst_valid", DATA_W'(out_valid), '0);

    // Counter saturation over 20 stalled cycles.
    step(1'b1, 16'h0033, 160'h55, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 15; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("sat_at_15", DATA_W'(stall_cnt), DATA_W'(15));
    for (int k = 0; k < 5; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("sat_at_20", DATA_W'(stall_cnt), DATA_W'(15));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    check("sat_drain_valid", DATA_W'(out_valid), '0);
    check("sat_drain_stall", DATA_W'(stall_cnt), DATA_W'(15));

    // Mixed handshake pattern with two flushes, checked by the model.
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    vpat = 32'b1101_1110_0111_1011_1111_0010_1110_1101;
    rpat = 32'b1010_0111_1100_1011_0011_1111_0101_1001;
    for (int i = 0; i < 32; i++) begin
      step(vpat[i], CTRL_W'(16'h0100 + i), DATA_W'(32'h100 + i), rpat[i],
           (i == 11) || (i == 23), 1'b1);
    end
    for (int k = 0; k < 4; k++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    check("mix_drained", DATA_W'(out_valid), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
